// File: rtl/grid_pkg.sv
// Shared board encodings, result codes, sequencer states and win-line table
// for the tic-tac-toe match logic.
package grid_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_X     = 2'b01;
   localparam logic [1:0] CELL_O     = 2'b10;
   localparam logic [1:0] CELL_SEL   = 2'b11;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_X    = 2'b01;
   localparam logic [1:0] RES_O    = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HUMAN_WAIT,
      S_THINK,
      S_AI_WAIT,
      S_COMMIT,
      S_DONE
   } seq_state_t;

   typedef logic [3:0] cell_idx_t;

   localparam int unsigned WIN_LINES = 8;

   localparam cell_idx_t WIN_LINE [WIN_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
   };

endpackage

// File: rtl/grid_line_eval.sv
// Combinational board evaluator: win detection for both pieces, per-cell
// empty flags and the lowest-index empty cell.
module grid_line_eval
   import grid_pkg::*;
(
   input  logic [17:0] grid,
   output logic        x_win,
   output logic        o_win,
   output logic [3:0]  lowest_empty,
   output logic [8:0]  empty_cells
);

   logic [1:0]           cells [9];
   logic [WIN_LINES-1:0] line_x;
   logic [WIN_LINES-1:0] line_o;

   for (genvar g = 0; g < 9; g++) begin : g_cell
      assign cells[g]       = grid[2*g +: 2];
      assign empty_cells[g] = (cells[g] == CELL_EMPTY);
   end

   for (genvar l = 0; l < WIN_LINES; l++) begin : g_line
      assign line_x[l] = (cells[WIN_LINE[l][0]] == CELL_X) &&
                         (cells[WIN_LINE[l][1]] == CELL_X) &&
                         (cells[WIN_LINE[l][2]] == CELL_X);
      assign line_o[l] = (cells[WIN_LINE[l][0]] == CELL_O) &&
                         (cells[WIN_LINE[l][1]] == CELL_O) &&
                         (cells[WIN_LINE[l][2]] == CELL_O);
   end

   assign x_win = |line_x;
   assign o_win = |line_o;

   always_comb begin
      lowest_empty = 4'd0;
      casez (empty_cells)
         9'b????????1: lowest_empty = 4'd0;
         9'b???????10: lowest_empty = 4'd1;
         9'b??????100: lowest_empty = 4'd2;
         9'b?????1000: lowest_empty = 4'd3;
         9'b????10000: lowest_empty = 4'd4;
         9'b???100000: lowest_empty = 4'd5;
         9'b??1000000: lowest_empty = 4'd6;
         9'b?10000000: lowest_empty = 4'd7;
         9'b100000000: lowest_empty = 4'd8;
         default:      lowest_empty = 4'd0;
      endcase
   end

endmodule

// File: rtl/match_sequencer.sv
// Turn scheduler for player-vs-AI tic-tac-toe: owns the board, paces the AI
// handshake with a thinking delay and timeout, and detects win/draw.
module match_sequencer
   import grid_pkg::*;
#(
   parameter int unsigned THINK_CYCLES = 200_000_000,
   parameter int unsigned AI_TIMEOUT   = 50_000_000
) (
   input  logic        clk,
   input  logic        reset_flag,
   input  logic        start_game,
   input  logic        ai_first,
   input  logic        human_valid,
   input  logic [3:0]  human_cell,
   output logic        ai_start,
   input  logic        ai_done,
   input  logic [3:0]  ai_cell,
   output logic [17:0] grid_state,
   output logic        turn,
   output logic        ai_waiting,
   output logic [1:0]  game_result,
   output logic        illegal_move,
   output logic        ai_fault,
   output logic [3:0]  move_count
);

   localparam int unsigned CNT_MAX = (THINK_CYCLES > AI_TIMEOUT) ? THINK_CYCLES : AI_TIMEOUT;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] THINK_LOAD = CW'(THINK_CYCLES - 1);
   localparam logic [CW-1:0] AI_LOAD    = CW'(AI_TIMEOUT - 1);

   seq_state_t  state, state_nx;
   logic        evaluating, evaluating_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]  pend_cell, pend_cell_nx;
   logic [1:0]  pend_piece, pend_piece_nx;
   logic [17:0] grid_nx, grid_wr;
   logic        turn_nx, ai_start_nx, illegal_nx, fault_nx;
   logic [1:0]  result_nx;
   logic [3:0]  count_nx;

   logic        x_win, o_win;
   logic [3:0]  lowest_empty;
   logic [8:0]  empty_cells;
   logic [8:0]  write_sel;
   logic        human_legal, ai_legal;

   grid_line_eval u_eval (
      .grid         (grid_state),
      .x_win        (x_win),
      .o_win        (o_win),
      .lowest_empty (lowest_empty),
      .empty_cells  (empty_cells)
   );

   assign human_legal = (human_cell <= 4'd8) && |(empty_cells & (9'd1 << human_cell));
   assign ai_legal    = (ai_cell <= 4'd8) && |(empty_cells & (9'd1 << ai_cell));
   assign write_sel   = 9'd1 << pend_cell;

   for (genvar g = 0; g < 9; g++) begin : g_write
      assign grid_wr[2*g +: 2] = write_sel[g] ? pend_piece : grid_state[2*g +: 2];
   end

   assign ai_waiting = (state == S_THINK) || (state == S_AI_WAIT);

   always_comb begin
      state_nx      = state;
      evaluating_nx = 1'b0;
      cnt_nx        = cnt;
      pend_cell_nx  = pend_cell;
      pend_piece_nx = pend_piece;
      grid_nx       = grid_state;
      turn_nx       = turn;
      result_nx     = game_result;
      count_nx      = move_count;
      ai_start_nx   = 1'b0;
      illegal_nx    = 1'b0;
      fault_nx      = 1'b0;

      if (start_game) begin
         grid_nx   = '0;
         count_nx  = '0;
         result_nx = RES_NONE;
         turn_nx   = ai_first;
         if (ai_first) begin
            state_nx = S_THINK;
            cnt_nx   = THINK_LOAD;
         end else begin
            state_nx = S_HUMAN_WAIT;
         end
      end else begin
         case (state)
            S_HUMAN_WAIT: begin
               if (human_valid) begin
                  if (human_legal) begin
                     pend_cell_nx  = human_cell;
                     pend_piece_nx = CELL_X;
                     state_nx      = S_COMMIT;
                  end else begin
                     illegal_nx = 1'b1;
                  end
               end
            end
            S_THINK: begin
               if (cnt == '0) begin
                  ai_start_nx = 1'b1;
                  cnt_nx      = AI_LOAD;
                  state_nx    = S_AI_WAIT;
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            S_AI_WAIT: begin
               // ai_done is checked first so it wins over a same-cycle timeout
               if (ai_done && ai_legal) begin
                  pend_cell_nx  = ai_cell;
                  pend_piece_nx = CELL_O;
                  state_nx      = S_COMMIT;
               end else if (ai_done || cnt == '0) begin
                  fault_nx      = 1'b1;
                  pend_cell_nx  = lowest_empty;
                  pend_piece_nx = CELL_O;
                  state_nx      = S_COMMIT;
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            S_COMMIT: begin
               // first cycle writes the board, second evaluates the registered result
               if (!evaluating) begin
                  grid_nx       = grid_wr;
                  count_nx      = move_count + 4'd1;
                  evaluating_nx = 1'b1;
               end else if (x_win) begin
                  result_nx = RES_X;
                  state_nx  = S_DONE;
               end else if (o_win) begin
                  result_nx = RES_O;
                  state_nx  = S_DONE;
               end else if (move_count == 4'd9) begin
                  result_nx = RES_DRAW;
                  state_nx  = S_DONE;
               end else begin
                  turn_nx = ~turn;
                  if (turn) begin
                     state_nx = S_HUMAN_WAIT;
                  end else begin
                     state_nx = S_THINK;
                     cnt_nx   = THINK_LOAD;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_flag) begin
      if (reset_flag) begin
         state        <= S_IDLE;
         evaluating   <= 1'b0;
         cnt          <= '0;
         pend_cell    <= '0;
         pend_piece   <= CELL_EMPTY;
         grid_state   <= '0;
         turn         <= 1'b0;
         game_result  <= RES_NONE;
         move_count   <= '0;
         ai_start     <= 1'b0;
         illegal_move <= 1'b0;
         ai_fault     <= 1'b0;
      end else begin
         state        <= state_nx;
         evaluating   <= evaluating_nx;
         cnt          <= cnt_nx;
         pend_cell    <= pend_cell_nx;
         pend_piece   <= pend_piece_nx;
         grid_state   <= grid_nx;
         turn         <= turn_nx;
         game_result  <= result_nx;
         move_count   <= count_nx;
         ai_start     <= ai_start_nx;
         illegal_move <= illegal_nx;
         ai_fault     <= fault_nx;
      end
   end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with THINK_CYCLES=4, AI_TIMEOUT=8;
// inputs change and outputs are sampled on the falling clock edge.
module tb_match_sequencer;

   logic        clk;
   logic        reset_flag;
   logic        start_game;
   logic        ai_first;
   logic        human_valid;
   logic [3:0]  human_cell;
   logic        ai_start;
   logic        ai_done;
   logic [3:0]  ai_cell;
   logic [17:0] grid_state;
   logic        turn;
   logic        ai_waiting;
   logic [1:0]  game_result;
   logic        illegal_move;
   logic        ai_fault;
   logic [3:0]  move_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   match_sequencer #(
      .THINK_CYCLES (4),
      .AI_TIMEOUT   (8)
   ) dut (
      .clk          (clk),
      .reset_flag   (reset_flag),
      .start_game   (start_game),
      .ai_first     (ai_first),
      .human_valid  (human_valid),
      .human_cell   (human_cell),
      .ai_start     (ai_start),
      .ai_done      (ai_done),
      .ai_cell      (ai_cell),
      .grid_state   (grid_state),
      .turn         (turn),
      .ai_waiting   (ai_waiting),
      .game_result  (game_result),
      .illegal_move (illegal_move),
      .ai_fault     (ai_fault),
      .move_count   (move_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic new_game(input logic af);
      start_game = 1'b1;
      ai_first   = af;
      tick();
      start_game = 1'b0;
      ai_first   = 1'b0;
   endtask

   task automatic strobe(input logic [3:0] c);
      human_valid = 1'b1;
      human_cell  = c;
      tick();
      human_valid = 1'b0;
   endtask

   // strobe, commit, evaluate: returns once turn/result reflect the move
   task automatic do_human(input logic [3:0] c);
      strobe(c);
      tick();
      tick();
   endtask

   task automatic wait_start();
      for (int i = 0; i < 20 && ai_start !== 1'b1; i++) tick();
      check("ai_start_seen", {31'd0, ai_start}, 32'd1);
   endtask

   task automatic ai_move(input logic [3:0] c);
      wait_start();
      ai_done = 1'b1;
      ai_cell = c;
      tick();
      ai_done = 1'b0;
      tick();
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grid"},   {14'd0, grid_state}, 32'd0);
      check({tag, "_result"}, {30'd0, game_result}, 32'd0);
      check({tag, "_count"},  {28'd0, move_count}, 32'd0);
      check({tag, "_turn"},   {31'd0, turn}, 32'd0);
      check({tag, "_wait"},   {31'd0, ai_waiting}, 32'd0);
      check({tag, "_start"},  {31'd0, ai_start}, 32'd0);
      check({tag, "_illeg"},  {31'd0, illegal_move}, 32'd0);
      check({tag, "_fault"},  {31'd0, ai_fault}, 32'd0);
   endtask

   initial begin
      reset_flag  = 1'b0;
      start_game  = 1'b0;
      ai_first    = 1'b0;
      human_valid = 1'b0;
      human_cell  = 4'd0;
      ai_done     = 1'b0;
      ai_cell     = 4'd0;
      #1 reset_flag = 1'b1;
      tick();
      tick();
      check_all_zero("rst");
      reset_flag = 1'b0;
      tick();

      // Game 1: human wins on row 0-1-2
      new_game(1'b0);
      check("g1_turn0", {31'd0, turn}, 32'd0);
      strobe(4'd0);
      tick();
      check("g1_grid_m1", {14'd0, grid_state}, 32'h00001);
      tick();
      check("g1_turn_ai", {31'd0, turn}, 32'd1);
      check("g1_waiting", {31'd0, ai_waiting}, 32'd1);
      check("g1_count1", {28'd0, move_count}, 32'd1);
      tick(); tick(); tick();
      check("g1_start_early", {31'd0, ai_start}, 32'd0);
      tick();
      check("g1_start_latency", {31'd0, ai_start}, 32'd1);
      ai_move(4'd3);
      do_human(4'd1);
      ai_move(4'd4);
      strobe(4'd2);
      tick();
      check("g1_grid_final", {14'd0, grid_state}, 32'h00295);
      check("g1_result_pre", {30'd0, game_result}, 32'd0);
      tick();
      check("g1_result_x", {30'd0, game_result}, 32'd1);
      check("g1_count5", {28'd0, move_count}, 32'd5);
      strobe(4'd5);
      check("g1_done_no_illeg", {31'd0, illegal_move}, 32'd0);
      tick(); tick();
      check("g1_done_grid_hold", {14'd0, grid_state}, 32'h00295);
      check("g1_result_hold", {30'd0, game_result}, 32'd1);

      // Game 2: illegal human moves, AI timeout, illegal AI cell
      new_game(1'b0);
      check("g2_cleared", {14'd0, grid_state}, 32'd0);
      do_human(4'd4);
      strobe(4'd5);
      check("g2_think_no_illeg", {31'd0, illegal_move}, 32'd0);
      ai_move(4'd0);
      check("g2_grid_m2", {14'd0, grid_state}, 32'h00102);
      strobe(4'd4);
      check("g2_illeg_occupied", {31'd0, illegal_move}, 32'd1);
      tick();
      check("g2_illeg_width1", {31'd0, illegal_move}, 32'd0);
      strobe(4'd9);
      check("g2_illeg_range", {31'd0, illegal_move}, 32'd1);
      tick();
      check("g2_illeg_width2", {31'd0, illegal_move}, 32'd0);
      check("g2_grid_unchanged", {14'd0, grid_state}, 32'h00102);
      check("g2_count2", {28'd0, move_count}, 32'd2);
      check("g2_turn_human", {31'd0, turn}, 32'd0);
      do_human(4'd8);
      check("g2_grid_m3", {14'd0, grid_state}, 32'h10102);
      wait_start();
      repeat (7) tick();
      check("g2_fault_early", {31'd0, ai_fault}, 32'd0);
      tick();
      check("g2_fault_timeout", {31'd0, ai_fault}, 32'd1);
      tick();
      check("g2_fault_width", {31'd0, ai_fault}, 32'd0);
      check("g2_grid_lowest", {14'd0, grid_state}, 32'h1010A);
      tick();
      check("g2_turn_back", {31'd0, turn}, 32'd0);
      check("g2_count4", {28'd0, move_count}, 32'd4);
      check("g2_wait_low", {31'd0, ai_waiting}, 32'd0);
      do_human(4'd2);
      wait_start();
      ai_done = 1'b1;
      ai_cell = 4'd4;
      tick();
      ai_done = 1'b0;
      check("g2_fault_badcell", {31'd0, ai_fault}, 32'd1);
      tick();
      check("g2_grid_subst", {14'd0, grid_state}, 32'h1019A);
      tick();
      check("g2_count6", {28'd0, move_count}, 32'd6);

      // Game 3: draw after nine moves
      new_game(1'b0);
      do_human(4'd0); ai_move(4'd4);
      do_human(4'd8); ai_move(4'd1);
      do_human(4'd7); ai_move(4'd6);
      do_human(4'd2); ai_move(4'd5);
      do_human(4'd3);
      check("g3_grid", {14'd0, grid_state}, 32'h16A59);
      check("g3_result_draw", {30'd0, game_result}, 32'd3);
      check("g3_count9", {28'd0, move_count}, 32'd9);

      // Game 4: X completes 6-7-8 on the ninth move
      new_game(1'b0);
      do_human(4'd1); ai_move(4'd0);
      do_human(4'd3); ai_move(4'd2);
      do_human(4'd6); ai_move(4'd4);
      do_human(4'd7); ai_move(4'd5);
      do_human(4'd8);
      check("g4_grid", {14'd0, grid_state}, 32'h15A66);
      check("g4_result_win9", {30'd0, game_result}, 32'd1);
      check("g4_count9", {28'd0, move_count}, 32'd9);

      // Game 5: AI first, done-vs-timeout priority, restart, async reset
      new_game(1'b1);
      check("g5_cleared", {14'd0, grid_state}, 32'd0);
      check("g5_result_clr", {30'd0, game_result}, 32'd0);
      check("g5_turn_ai", {31'd0, turn}, 32'd1);
      check("g5_waiting", {31'd0, ai_waiting}, 32'd1);
      wait_start();
      repeat (7) tick();
      ai_done = 1'b1;
      ai_cell = 4'd4;
      tick();
      ai_done = 1'b0;
      check("g5_prio_no_fault", {31'd0, ai_fault}, 32'd0);
      tick();
      check("g5_prio_grid", {14'd0, grid_state}, 32'h00200);
      tick();
      check("g5_turn_human", {31'd0, turn}, 32'd0);
      do_human(4'd0);
      check("g5_grid_m2", {14'd0, grid_state}, 32'h00201);
      wait_start();
      tick();
      tick();
      new_game(1'b0);
      check("g5_restart_grid", {14'd0, grid_state}, 32'd0);
      check("g5_restart_count", {28'd0, move_count}, 32'd0);
      check("g5_restart_wait", {31'd0, ai_waiting}, 32'd0);
      ai_done = 1'b1;
      ai_cell = 4'd4;
      tick();
      ai_done = 1'b0;
      check("g5_late_no_fault", {31'd0, ai_fault}, 32'd0);
      tick();
      tick();
      check("g5_late_ignored", {14'd0, grid_state}, 32'd0);
      do_human(4'd4);
      check("g5_grid_after", {14'd0, grid_state}, 32'h00100);
      tick();
      check("g5_think_wait", {31'd0, ai_waiting}, 32'd1);
      #2 reset_flag = 1'b1;
      #1;
      check_all_zero("async_rst");
      tick();
      reset_flag = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
